spawn_request_scheduler: RTL and testbench

Consumer side of the random-tick interface. Takes the randomTick1/randomTick2 levels from the random tick generator and turns each new assertion into one spawn request. Requests are buffered in a small FIFO. They are then issued to the enemy object engine over a valid/ready handshake, throttled by a minimum gap measured in game ticks and by a cap on the number of enemies alive at once.

---
 rtl/spawn_request_scheduler_pkg.sv | 20 ++
 rtl/spawn_request_scheduler_fifo.sv | 73 +++++++
 rtl/spawn_request_scheduler.sv | 177 +++++++++++++++++
 tb/tb_spawn_request_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spawn_request_scheduler_pkg.sv
// Shared types and default constants for the spawn request scheduler.
// The spawn entry struct fixes the lane width used throughout the block.
package spawn_request_scheduler_pkg;

  localparam int SPAWN_LANE_W      = 2;
  localparam int DEF_MIN_GAP_TICKS = 8;
  localparam int DEF_MAX_ACTIVE    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                    stype;
    logic [SPAWN_LANE_W-1:0] lane;
  } spawn_entry_t;

endpackage

// File: rtl/spawn_request_scheduler_fifo.sv
// Small synchronous FIFO holding pending spawn entries. rd_data is the current head.
// A write into a full FIFO succeeds only when a read happens in the same cycle.
module spawn_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          wr_drop
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && !empty_q;
    do_wr    = wr_en && (!full_q || do_rd);
    wr_drop  = wr_en && !do_wr;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/spawn_request_scheduler.sv
// Turns rising randomTick levels into queued spawn requests and issues them to the
// object engine, throttled by a game-tick gap and a cap on live enemies.
module spawn_request_scheduler
  import spawn_request_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH   = 4,
  parameter int MIN_GAP_TICKS = DEF_MIN_GAP_TICKS,
  parameter int MAX_ACTIVE    = DEF_MAX_ACTIVE,
  parameter int LANE_W        = SPAWN_LANE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              gameTick,
  input  logic              randomTick1,
  input  logic              randomTick2,
  input  logic              enemyDestroyed,
  input  logic              spawnReady,
  output logic              spawnValid,
  output logic              spawnType,
  output logic [LANE_W-1:0] spawnLane,
  output logic [2:0]        activeCount,
  output logic              queueFull,
  output logic              droppedRequest,
  output sched_state_t      dbg_state
);

  // Handshake: spawnValid stays high with stable spawnType/spawnLane until spawnReady
  // is high at a rising clock edge; the spawn transfers on exactly that edge.

  localparam int CW    = $clog2(QUEUE_DEPTH) + 1;
  localparam int GAP_W = (MIN_GAP_TICKS > 0) ? $clog2(MIN_GAP_TICKS + 1) : 1;

  logic              tick1_q, tick2_q;
  logic              req1, req2;
  logic [LANE_W-1:0] lane_q;
  logic              hold_valid_q, hold_valid_d;
  spawn_entry_t      hold_q, hold_d;
  spawn_entry_t      e1, e2, wr_data, head;
  logic              wr_en, pop, accept;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_drop;
  sched_state_t      state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [2:0]        active_q, active_d;
  logic              dropped_q;

  spawn_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     ($bits(spawn_entry_t))
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .wr_drop (fifo_drop)
  );

  // Write arbitration: a parked entry goes first; tick1 beats a simultaneous tick2,
  // which waits one cycle in the hold register with its original lane.
  always_comb begin
    req1         = randomTick1 && !tick1_q;
    req2         = randomTick2 && !tick2_q;
    e1           = '{stype: 1'b0, lane: lane_q};
    e2           = '{stype: 1'b1, lane: lane_q};
    wr_en        = 1'b0;
    wr_data      = '0;
    hold_valid_d = 1'b0;
    hold_d       = hold_q;
    if (hold_valid_q) begin
      wr_en   = 1'b1;
      wr_data = hold_q;
      if (req1) begin
        hold_valid_d = 1'b1;
        hold_d       = e1;
      end else if (req2) begin
        hold_valid_d = 1'b1;
        hold_d       = e2;
      end
    end else if (req1) begin
      wr_en   = 1'b1;
      wr_data = e1;
      if (req2) begin
        hold_valid_d = 1'b1;
        hold_d       = e2;
      end
    end else if (req2) begin
      wr_en   = 1'b1;
      wr_data = e2;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (active_q < 3'(MAX_ACTIVE))) begin
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (spawnReady) begin
          pop    = 1'b1;
          accept = 1'b1;
          if (MIN_GAP_TICKS == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(MIN_GAP_TICKS);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else if (gameTick) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A spawn and a destruction in the same cycle cancel out.
    active_d = active_q;
    if (accept && !enemyDestroyed) begin
      active_d = active_q + 3'd1;
    end else if (!accept && enemyDestroyed && (active_q != 3'd0)) begin
      active_d = active_q - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick1_q      <= 1'b0;
      tick2_q      <= 1'b0;
      lane_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      active_q     <= 3'd0;
      dropped_q    <= 1'b0;
    end else begin
      tick1_q      <= randomTick1;
      tick2_q      <= randomTick2;
      lane_q       <= lane_q + LANE_W'(1);
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      state_q      <= state_d;
      gap_q        <= gap_d;
      active_q     <= active_d;
      dropped_q    <= fifo_drop;
    end
  end

  assign spawnValid     = (state_q == ST_OFFER);
  assign spawnType      = spawnValid ? head.stype : 1'b0;
  assign spawnLane      = spawnValid ? head.lane : '0;
  assign activeCount    = active_q;
  assign queueFull      = fifo_full;
  assign droppedRequest = dropped_q;
  assign dbg_state      = state_q;

  offer_has_entry: assert property (@(posedge clock) disable iff (!reset_n)
    (state_q == ST_OFFER) |-> (fifo_count != '0));

endmodule

// File: tb/tb_spawn_request_scheduler.sv
// Directed bench for spawn_request_scheduler: dut uses the default gap of 8 ticks,
// dut0 shares the stimulus but runs with no gap.
module tb_spawn_request_scheduler;
  import spawn_request_scheduler_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic gameTick = 1'b0;
  logic randomTick1 = 1'b0;
  logic randomTick2 = 1'b0;
  logic enemyDestroyed = 1'b0;
  logic spawnReady = 1'b0;

  logic         a_valid, a_type, a_full, a_drop;
  logic [1:0]   a_lane;
  logic [2:0]   a_active;
  sched_state_t a_state;
  logic         b_valid, b_type, b_full, b_drop;
  logic [1:0]   b_lane;
  logic [2:0]   b_active;
  sched_state_t b_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  spawn_request_scheduler dut (
    .clock(clock), .reset_n(reset_n), .gameTick(gameTick),
    .randomTick1(randomTick1), .randomTick2(randomTick2),
    .enemyDestroyed(enemyDestroyed), .spawnReady(spawnReady),
    .spawnValid(a_valid), .spawnType(a_type), .spawnLane(a_lane),
    .activeCount(a_active), .queueFull(a_full), .droppedRequest(a_drop),
    .dbg_state(a_state)
  );

  spawn_request_scheduler #(.MIN_GAP_TICKS(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .gameTick(gameTick),
    .randomTick1(randomTick1), .randomTick2(randomTick2),
    .enemyDestroyed(enemyDestroyed), .spawnReady(spawnReady),
    .spawnValid(b_valid), .spawnType(b_type), .spawnLane(b_lane),
    .activeCount(b_active), .queueFull(b_full), .droppedRequest(b_drop),
    .dbg_state(b_state)
  );

  always #5 clock = ~clock;

  // cyc tracks the DUT lane counter: lane == cyc % 4 between edges.
  task step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task do_reset();
    reset_n = 1'b0;
    gameTick = 1'b0;
    randomTick1 = 1'b0;
    randomTick2 = 1'b0;
    enemyDestroyed = 1'b0;
    spawnReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task wait_lane(input int l);
    for (int i = 0; i < 4 && (cyc % 4) != l; i++) step();
  endtask

  task test_reset();
    do_reset();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", a_valid); end
    checks++; if (a_type !== 1'b0) begin errors++; $display("FAIL reset_type got=%0b want=0", a_type); end
    checks++; if (a_lane !== 2'd0) begin errors++; $display("FAIL reset_lane got=%0d want=0", a_lane); end
    checks++; if (a_active !== 3'd0) begin errors++; $display("FAIL reset_active got=%0d want=0", a_active); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b want=0", a_full); end
    checks++; if (a_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%0b want=0", a_drop); end
    checks++; if (a_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", a_state, ST_IDLE); end
    enemyDestroyed = 1'b1;
    step();
    enemyDestroyed = 1'b0;
    checks++; if (a_active !== 3'd0) begin errors++; $display("FAIL active_saturate got=%0d want=0", a_active); end
  endtask

  task test_single();
    do_reset();
    spawnReady = 1'b1;
    wait_lane(2);
    randomTick1 = 1'b1;
    step();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0b want=0", a_valid); end
    step();
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", a_valid); end
    checks++; if (a_type !== 1'b0) begin errors++; $display("FAIL single_type got=%0b want=0", a_type); end
    checks++; if (a_lane !== 2'd2) begin errors++; $display("FAIL single_lane got=%0d want=2", a_lane); end
    step();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got=%0b want=0", a_valid); end
    checks++; if (a_active !== 3'd1) begin errors++; $display("FAIL single_active got=%0d want=1", a_active); end
    checks++; if (a_state !== ST_GAP) begin errors++; $display("FAIL single_gap got=%0d want=%0d", a_state, ST_GAP); end
    randomTick1 = 1'b0;
  endtask

  task test_simultaneous();
    do_reset();
    spawnReady = 1'b1;
    wait_lane(1);
    randomTick1 = 1'b1;
    randomTick2 = 1'b1;
    step();
    randomTick1 = 1'b0;
    randomTick2 = 1'b0;
    step();
    checks++; if (a_valid !== 1'b1 || a_type !== 1'b0 || a_lane !== 2'd1) begin
      errors++; $display("FAIL simul_first got=v%0b t%0b l%0d want=v1 t0 l1", a_valid, a_type, a_lane); end
    step();
    checks++; if (a_valid !== 1'b0 || a_active !== 3'd1) begin
      errors++; $display("FAIL simul_accept got=v%0b a%0d want=v0 a1", a_valid, a_active); end
    for (int i = 0; i < 8; i++) begin
      gameTick = 1'b1;
      step();
      gameTick = 1'b0;
      step();
      if (i == 6) begin
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL simul_gap7 got=%0b want=0", a_valid); end
      end
    end
    checks++; if (a_valid !== 1'b1 || a_type !== 1'b1 || a_lane !== 2'd1) begin
      errors++; $display("FAIL simul_second got=v%0b t%0b l%0d want=v1 t1 l1", a_valid, a_type, a_lane); end
    step();
    checks++; if (a_active !== 3'd2) begin errors++; $display("FAIL simul_active got=%0d want=2", a_active); end
  endtask

  task test_held_level();
    int hs;
    int drops;
    hs = 0;
    drops = 0;
    do_reset();
    spawnReady = 1'b1;
    randomTick2 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) randomTick2 = 1'b0;
      if (b_valid && spawnReady) hs++;
      if (b_drop) drops++;
      step();
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL held_handshakes got=%0d want=1", hs); end
    checks++; if (b_active !== 3'd1) begin errors++; $display("FAIL held_active got=%0d want=1", b_active); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL held_drops got=%0d want=0", drops); end
  endtask

  task test_overflow();
    int drops;
    drops = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if ((i % 2) == 0) randomTick1 = 1'b1;
      else randomTick2 = 1'b1;
      step();
      if (a_drop) drops++;
      randomTick1 = 1'b0;
      randomTick2 = 1'b0;
      step();
      if (a_drop) drops++;
    end
    repeat (3) begin
      step();
      if (a_drop) drops++;
    end
    checks++; if (drops !== 2) begin errors++; $display("FAIL ovf_drops got=%0d want=2", drops); end
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%0b want=1", a_full); end
    checks++; if (a_valid !== 1'b1 || a_type !== 1'b0 || a_lane !== 2'd0) begin
      errors++; $display("FAIL ovf_head got=v%0b t%0b l%0d want=v1 t0 l0", a_valid, a_type, a_lane); end
    randomTick1 = 1'b1;
    spawnReady = 1'b1;
    step();
    randomTick1 = 1'b0;
    spawnReady = 1'b0;
    checks++; if (a_drop !== 1'b0) begin errors++; $display("FAIL full_pop_drop got=%0b want=0", a_drop); end
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL full_pop_full got=%0b want=1", a_full); end
    checks++; if (a_active !== 3'd1) begin errors++; $display("FAIL full_pop_active got=%0d want=1", a_active); end
  endtask

  task test_cap();
    int late;
    late = 0;
    do_reset();
    spawnReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      randomTick1 = 1'b1;
      step();
      randomTick1 = 1'b0;
      repeat (3) step();
    end
    repeat (10) step();
    checks++; if (b_active !== 3'd6) begin errors++; $display("FAIL cap_active got=%0d want=6", b_active); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL cap_valid got=%0b want=0", b_valid); end
    enemyDestroyed = 1'b1;
    step();
    enemyDestroyed = 1'b0;
    checks++; if (b_active !== 3'd5) begin errors++; $display("FAIL cap_destroy got=%0d want=5", b_active); end
    step();
    checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL cap_reoffer got=%0b want=1", b_valid); end
    step();
    checks++; if (b_active !== 3'd6) begin errors++; $display("FAIL cap_refill got=%0d want=6", b_active); end
    repeat (6) begin
      if (b_valid) late++;
      step();
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL cap_hold got=%0d offers want=0", late); end
  endtask

  task test_async_reset();
    int stray;
    stray = 0;
    do_reset();
    spawnReady = 1'b1;
    gameTick = 1'b1;
    randomTick1 = 1'b1;
    step();
    randomTick1 = 1'b0;
    repeat (14) step();
    spawnReady = 1'b0;
    gameTick = 1'b0;
    randomTick1 = 1'b1; step(); randomTick1 = 1'b0; step();
    randomTick2 = 1'b1; step(); randomTick2 = 1'b0; step();
    randomTick1 = 1'b1; step(); randomTick1 = 1'b0; step();
    step();
    checks++; if (a_valid !== 1'b1 || a_active !== 3'd1) begin
      errors++; $display("FAIL arst_pre got=v%0b a%0d want=v1 a1", a_valid, a_active); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%0b want=0", a_valid); end
    checks++; if (a_active !== 3'd0) begin errors++; $display("FAIL arst_active got=%0d want=0", a_active); end
    checks++; if (a_state !== ST_IDLE) begin errors++; $display("FAIL arst_state got=%0d want=%0d", a_state, ST_IDLE); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    spawnReady = 1'b1;
    repeat (12) begin
      if (a_valid) stray++;
      step();
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL arst_stray got=%0d offers want=0", stray); end
    randomTick1 = 1'b1;
    step();
    randomTick1 = 1'b0;
    step();
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL arst_new got=%0b want=1", a_valid); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_held_level();
    test_overflow();
    test_cap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
